// File: rtl/ascii2bcd_pkg.sv
// Shared constants, FSM state type and a BCD-pair helper for the ASCII-to-BCD converter.
package ascii2bcd_pkg;

    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_NINE    = 8'h39;
    localparam logic [3:0] BCD_INVALID   = 4'hF;
    localparam logic [3:0] MAX_HOUR_TENS = 4'd2;
    localparam logic [7:0] MAX_HOURS     = 8'd23;
    localparam logic [7:0] MAX_MINSEC    = 8'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Binary value of a two-digit BCD field; 8 bits covers even 4'hF nibbles.
    function automatic logic [7:0] bcd_pair(input logic [3:0] tens, input logic [3:0] units);
        return ({4'd0, tens} * 8'd10) + {4'd0, units};
    endfunction

endpackage

// File: rtl/ascii2bcd_multi_if.sv
// Request/result bundle between a client (master) and the ASCII-to-BCD converter (slave).
// Handshake: inicio is a request accepted on any edge where busy=0; busy=1 means not ready,
// and done is a level that stays high with BCD/err/err_idx until the next accepted request.
interface ascii2bcd_multi_if #(
    parameter int NDIG = 6,
    parameter int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1
) ();

    logic                inicio;
    logic [8*NDIG-1:0]   Ascii;
    logic [4*NDIG-1:0]   BCD;
    logic                busy;
    logic                done;
    logic                err;
    logic [IDXW-1:0]     err_idx;

    modport master (
        output inicio, Ascii,
        input  BCD, busy, done, err, err_idx
    );

    modport slave (
        input  inicio, Ascii,
        output BCD, busy, done, err, err_idx
    );

endinterface

// File: rtl/ascii_digit_decode.sv
// Combinational ASCII byte to {BCD nibble, valid} decoder; non-digits give 4'hF.
module ascii_digit_decode
    import ascii2bcd_pkg::*;
(
    input  logic [7:0] char_i,
    output logic [3:0] nibble_o,
    output logic       valid_o
);

    always_comb begin
        valid_o  = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
        // Low nibble of '0'..'9' is already the digit value.
        nibble_o = valid_o ? char_i[3:0] : BCD_INVALID;
    end

endmodule

// File: rtl/ascii2bcd_multi.sv
// Serial NDIG-character ASCII-to-BCD converter, one digit per cycle, single atomic commit.
// Optional clock-field range check (NDIG==6 only) enabled by macro ASCII2BCD_RANGE_CHECK_EN.
module ascii2bcd_multi
    import ascii2bcd_pkg::*;
#(
    parameter int NDIG = 6,
    parameter int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                 clk,
    input  logic                 init,
    ascii2bcd_multi_if.slave     bus,
    output state_e               state_o
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);

    state_e              state_q,   state_d;
    logic [8*NDIG-1:0]   shadow_q,  shadow_d;
    logic [4*NDIG-1:0]   work_q,    work_d;
    logic [4*NDIG-1:0]   bcd_q,     bcd_d;
    logic [IDXW-1:0]     idx_q,     idx_d;
    logic                bad_q,     bad_d;
    logic [IDXW-1:0]     bad_idx_q, bad_idx_d;
    logic                err_q,     err_d;
    logic [IDXW-1:0]     err_idx_q, err_idx_d;

    logic [7:0]          cur_char;
    logic [3:0]          dec_nibble;
    logic                dec_valid;
    logic                range_bad;
    logic [IDXW-1:0]     range_idx;

    // Byte for digit i sits at [8*(NDIG-i)-1 -: 8], so digit 0 is the top byte.
    assign cur_char = shadow_q[8*(NDIG-1-int'(idx_q)) +: 8];

    ascii_digit_decode u_decode (
        .char_i   (cur_char),
        .nibble_o (dec_nibble),
        .valid_o  (dec_valid)
    );

`ifdef ASCII2BCD_RANGE_CHECK_EN
    if (NDIG == 6) begin : g_range
        logic [7:0] hours, minutes, seconds;
        always_comb begin
            hours     = bcd_pair(work_q[23:20], work_q[19:16]);
            minutes   = bcd_pair(work_q[15:12], work_q[11:8]);
            seconds   = bcd_pair(work_q[7:4],   work_q[3:0]);
            range_bad = 1'b0;
            range_idx = '0;
            // Later tests override earlier ones so the highest offending field wins.
            if (seconds > MAX_MINSEC) begin
                range_bad = 1'b1;
                range_idx = IDXW'(1);
            end
            if (minutes > MAX_MINSEC) begin
                range_bad = 1'b1;
                range_idx = IDXW'(3);
            end
            if ((hours > MAX_HOURS) || (work_q[23:20] > MAX_HOUR_TENS)) begin
                range_bad = 1'b1;
                range_idx = IDXW'(5);
            end
        end
    end else begin : g_no_range
        assign range_bad = 1'b0;
        assign range_idx = '0;
    end
`else
    assign range_bad = 1'b0;
    assign range_idx = '0;
`endif

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        work_d    = work_q;
        bcd_d     = bcd_q;
        idx_d     = idx_q;
        bad_d     = bad_q;
        bad_idx_d = bad_idx_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.inicio) begin
                    shadow_d  = bus.Ascii;
                    idx_d     = '0;
                    bad_d     = 1'b0;
                    bad_idx_d = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                work_d[4*int'(idx_q) +: 4] = dec_nibble;
                // Digits are visited in ascending order, so the first invalid one is the lowest.
                if (!dec_valid && !bad_q) begin
                    bad_d     = 1'b1;
                    bad_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) state_d = CHECK;
                else                   idx_d   = idx_q + 1'b1;
            end
            CHECK: begin
                bcd_d     = work_q;
                err_d     = bad_q || range_bad;
                err_idx_d = bad_q ? bad_idx_q : (range_bad ? range_idx : '0);
                state_d   = DONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            work_q    <= '0;
            bcd_q     <= '0;
            idx_q     <= '0;
            bad_q     <= 1'b0;
            bad_idx_q <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            work_q    <= work_d;
            bcd_q     <= bcd_d;
            idx_q     <= idx_d;
            bad_q     <= bad_d;
            bad_idx_q <= bad_idx_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign bus.BCD     = bcd_q;
    assign bus.busy    = (state_q == CONV) || (state_q == CHECK);
    assign bus.done    = (state_q == DONE);
    assign bus.err     = err_q;
    assign bus.err_idx = err_idx_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ascii2bcd_multi.sv
// Directed self-checking bench for ascii2bcd_multi: NDIG=6 and NDIG=4 instances.
module tb_ascii2bcd_multi;
    import ascii2bcd_pkg::*;

`ifdef ASCII2BCD_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   init;
    state_e st6, st4;

    always #5 clk = ~clk;

    ascii2bcd_multi_if #(.NDIG(6), .IDXW(3)) bus6 ();
    ascii2bcd_multi_if #(.NDIG(4), .IDXW(2)) bus4 ();

    ascii2bcd_multi #(.NDIG(6)) u_dut6 (.clk(clk), .init(init), .bus(bus6), .state_o(st6));
    ascii2bcd_multi #(.NDIG(4)) u_dut4 (.clk(clk), .init(init), .bus(bus4), .state_o(st4));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] last_bcd6;
    logic [15:0] last_bcd4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Display-order string: first character is the highest digit, placed in byte [7:0].
    function automatic logic [47:0] a6(input string s);
        logic [47:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    function automatic logic [31:0] a4(input string s);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    task automatic wait_done(input bit sel4, output int cyc, output int bsy);
        cyc = 0;
        bsy = (sel4 ? bus4.busy : bus6.busy) ? 1 : 0;
        while (!(sel4 ? bus4.done : bus6.done) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (sel4 ? bus4.busy : bus6.busy) bsy++;
        end
    endtask

    task automatic conv6(input string tag, input string s, input logic [23:0] exp_bcd,
                         input logic exp_err, input logic [2:0] exp_idx);
        int cyc, bsy;
        @(negedge clk);
        bus6.inicio = 1'b1;
        bus6.Ascii  = a6(s);
        @(negedge clk);
        bus6.inicio = 1'b0;
        bus6.Ascii  = ~a6(s);
        check({tag, "_busy_t0"}, 32'(bus6.busy), 32'd1);
        check({tag, "_done_t0"}, 32'(bus6.done), 32'd0);
        check({tag, "_bcd_held"}, 32'(bus6.BCD), 32'(last_bcd6));
        wait_done(1'b0, cyc, bsy);
        check({tag, "_latency"}, 32'(cyc), 32'd7);
        check({tag, "_busy_cycles"}, 32'(bsy), 32'd7);
        check({tag, "_bcd"}, 32'(bus6.BCD), 32'(exp_bcd));
        check({tag, "_err"}, 32'(bus6.err), 32'(exp_err));
        check({tag, "_err_idx"}, 32'(bus6.err_idx), 32'(exp_idx));
        check({tag, "_state"}, 32'(st6), 32'(DONE));
        last_bcd6 = exp_bcd;
    endtask

    task automatic conv4(input string tag, input string s, input logic [15:0] exp_bcd,
                         input logic exp_err, input logic [1:0] exp_idx);
        int cyc, bsy;
        @(negedge clk);
        bus4.inicio = 1'b1;
        bus4.Ascii  = a4(s);
        @(negedge clk);
        bus4.inicio = 1'b0;
        bus4.Ascii  = ~a4(s);
        check({tag, "_bcd_held"}, 32'(bus4.BCD), 32'(last_bcd4));
        wait_done(1'b1, cyc, bsy);
        check({tag, "_latency"}, 32'(cyc), 32'd5);
        check({tag, "_busy_cycles"}, 32'(bsy), 32'd5);
        check({tag, "_bcd"}, 32'(bus4.BCD), 32'(exp_bcd));
        check({tag, "_err"}, 32'(bus4.err), 32'(exp_err));
        check({tag, "_err_idx"}, 32'(bus4.err_idx), 32'(exp_idx));
        last_bcd4 = exp_bcd;
    endtask

    initial begin
        int cyc, bsy;
        init        = 1'b1;
        bus6.inicio = 1'b0;
        bus6.Ascii  = '0;
        bus4.inicio = 1'b0;
        bus4.Ascii  = '0;
        last_bcd6   = '0;
        last_bcd4   = '0;
        repeat (3) @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        check("rst_bcd", 32'(bus6.BCD), 32'd0);
        check("rst_busy", 32'(bus6.busy), 32'd0);
        check("rst_done", 32'(bus6.done), 32'd0);
        check("rst_err", 32'(bus6.err), 32'd0);
        check("rst_err_idx", 32'(bus6.err_idx), 32'd0);
        check("rst_state", 32'(st6), 32'(IDLE));

        conv6("basic", "235959", 24'h235959, 1'b0, 3'd0);
        repeat (3) @(negedge clk);
        check("hold_done", 32'(bus6.done), 32'd1);
        check("hold_bcd", 32'(bus6.BCD), 32'h235959);

        conv6("colon", "12:456", 24'h12F456, 1'b1, 3'd3);
        conv6("multi_bad", "A2:4x6", 24'hF2F4F6, 1'b1, 3'd1);
        conv6("edges", "/09:90", 24'hF09F90, 1'b1, 3'd2);

        // inicio held high with Ascii changing after the latch edge
        @(negedge clk);
        bus6.inicio = 1'b1;
        bus6.Ascii  = a6("010203");
        @(negedge clk);
        bus6.Ascii  = a6("195959");
        wait_done(1'b0, cyc, bsy);
        check("held_latency", 32'(cyc), 32'd7);
        check("held_bcd", 32'(bus6.BCD), 32'h010203);
        @(negedge clk);
        bus6.inicio = 1'b0;
        check("restart_done", 32'(bus6.done), 32'd0);
        check("restart_busy", 32'(bus6.busy), 32'd1);
        check("restart_bcd_held", 32'(bus6.BCD), 32'h010203);
        wait_done(1'b0, cyc, bsy);
        check("restart_latency", 32'(cyc), 32'd7);
        check("restart_bcd", 32'(bus6.BCD), 32'h195959);
        last_bcd6 = 24'h195959;

        // reset during the third cycle of a conversion
        @(negedge clk);
        bus6.inicio = 1'b1;
        bus6.Ascii  = a6("111111");
        @(negedge clk);
        bus6.inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("midrst_bcd", 32'(bus6.BCD), 32'd0);
        check("midrst_busy", 32'(bus6.busy), 32'd0);
        check("midrst_done", 32'(bus6.done), 32'd0);
        check("midrst_err", 32'(bus6.err), 32'd0);
        check("midrst_state", 32'(st6), 32'(IDLE));
        repeat (10) @(negedge clk);
        check("midrst_no_commit", 32'(bus6.BCD), 32'd0);
        check("midrst_still_idle", 32'(bus6.done), 32'd0);
        last_bcd6 = '0;
        last_bcd4 = '0;
        conv6("fresh", "123456", 24'h123456, 1'b0, 3'd0);

        // clock-field range cases
        conv6("hrs24", "246000", 24'h246000, RC, RC ? 3'd5 : 3'd0);
        conv6("hrs_tens", "301000", 24'h301000, RC, RC ? 3'd5 : 3'd0);
        conv6("min_sec", "126070", 24'h126070, RC, RC ? 3'd3 : 3'd0);
        conv6("sec60", "125960", 24'h125960, RC, RC ? 3'd1 : 3'd0);
        conv6("char_prio", "2x6000", 24'h2F6000, 1'b1, 3'd4);

        conv4("n4_basic", "0909", 16'h0909, 1'b0, 2'd0);
        conv4("n4_bad", "x909", 16'hF909, 1'b1, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii2bcd_multi.md
Name: ascii2bcd_multi

Overview:
Parametrised, sequential ASCII-to-BCD converter for the clock/display path. It converts NDIG ASCII characters into packed BCD, one digit per cycle. It flags non-digit characters and, optionally, out-of-range clock fields. It replaces the per-digit converter bank in the time-setting path and raises a single done/err result toward the clock core.

Parameters:
- NDIG, 6, number of ASCII characters/BCD digits; legal range 1..16.
- IDXW, $clog2(NDIG) (minimum 1), width of the digit index.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- init, input, 1, synchronous active-high reset.
- inicio, input, 1, start request, sampled on the rising edge.
- Ascii, input, 8*NDIG, characters. Byte [8*(NDIG-i)-1 -: 8] maps to digit i.
- BCD, output, 4*NDIG, result. Nibble [4*i+3 -: 4] is digit i; for NDIG=6, digit 0 is seconds units and digit 5 is hours tens.
- busy, output, 1, conversion in progress.
- done, output, 1, result valid (level).
- err, output, 1, result contains an error; valid only while done=1.
- err_idx, output, IDXW, index of the lowest-numbered invalid digit; 0 when err=0.

Behaviour:
- Reset: when init=1 at an edge, the block goes to IDLE, and BCD, busy, done, err and err_idx are all 0. Reset overrides everything, including a conversion in progress; no partial result is committed.
- FSM states: IDLE, CONV, CHECK, DONE.
- IDLE or DONE, inicio=1:
  - Latch Ascii into a shadow register; later changes on Ascii are ignored.
  - Set idx=0, go to CONV, busy=1, done=0, err=0.
- CONV:
  - Each edge decodes shadow digit idx into the working register, then increments idx.
  - The edge that decodes digit NDIG-1 moves to CHECK.
  - inicio is ignored while in CONV or CHECK.
- Decode rule for each character:
  - 8'h30..8'h39 gives char-8'h30 and is valid.
  - Any other byte gives 4'hF and is invalid.
  - The lowest invalid index is recorded in err_idx.
- CHECK, exactly one cycle:
  - Evaluate the optional range check.
  - Commit the working register to BCD in a single update.
  - Go to DONE with done=1, busy=0, and err set if any digit was invalid or the range check failed.
- Latency: if inicio is sampled at edge T0, busy=1 after T0, and done=1 after edge T0+NDIG+1.
  - The conversion interval is NDIG+1 cycles.
  - Latency is constant regardless of content or macro setting.
- DONE:
  - BCD, done, err and err_idx hold until a new inicio or reset.
  - inicio=1 in DONE restarts the block exactly as from IDLE; done drops on that same edge.
- BCD holds the previous committed value throughout CONV and CHECK, so intermediate nibbles are never visible.
- If init and inicio are both high on the same edge, reset wins.
- idx never exceeds NDIG-1, so there is no wrap-around.

Optional Feature:
- Macro: ASCII2BCD_RANGE_CHECK_EN, effective only when NDIG==6.
- Defined: in CHECK, err is also set when any clock field is out of range:
  - hours: digits 5,4 > 23, or tens digit > 2;
  - minutes: digits 3,2 > 59;
  - seconds: digits 1,0 > 59.
  - In that case err_idx is the tens digit of the highest offending field (hours first).
  - Invalid-character errors take priority for err_idx.
- Not defined: only character validity sets err. CHECK still lasts one cycle.

Decomposition:
- Package ascii2bcd_pkg contains:
  - ASCII_ZERO=8'h30, ASCII_NINE=8'h39;
  - BCD_INVALID=4'hF;
  - the FSM state enum (IDLE/CONV/CHECK/DONE);
  - MAX_HOUR_TENS=2, MAX_HOURS=23, MAX_MINSEC=59.
- One natural sub-module: ascii_digit_decode, a combinational byte-to-{nibble, valid} decoder instantiated once and shared by the serial datapath.

Test Plan:
- Reset, then inicio pulse with Ascii="235959" (byte [7:0]='2') -> done after 7 cycles; BCD=24'h235959, err=0, busy high for exactly 7 cycles.
- Ascii="12:456" (byte [23:16]=':') -> BCD digit 3=4'hF, err=1, err_idx=3; other digits correct.
- Hold inicio high continuously during a conversion and change Ascii mid-flight -> no restart; result matches the Ascii value latched at T0; restarts on the first edge in DONE.
- Assert init at cycle 3 of a conversion -> all outputs 0 on the next edge, no commit; a fresh inicio then converts normally.
- With ASCII2BCD_RANGE_CHECK_EN, Ascii="246000" -> err=1, err_idx=5 (hours digit). Without the macro -> err=0, BCD=24'h246000.
- NDIG=4 instance, Ascii="0909" -> BCD=16'h0909, done after 5 cycles; err_idx width 2.
